// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: ExcCode values, reset PC, Tnew bounds.
package pipe_pkg;

  localparam logic [4:0]  EXC_INT       = 5'd0;
  localparam logic [4:0]  EXC_ADEL      = 5'd4;
  localparam logic [4:0]  EXC_ADES      = 5'd5;
  localparam logic [4:0]  EXC_RI        = 5'd10;
  localparam logic [4:0]  EXC_OV        = 5'd12;

  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;
  localparam int          TNEW_W_DEF    = 3;
  localparam int          TNEW_MAX      = (1 << TNEW_W_DEF) - 1;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency 1 cycle from inc to count; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, Tnew countdown and exception merge.
// Latency 1 cycle; stall holds contents, flush inserts a bubble that keeps PC/BD for EPC.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 128,
  parameter int          TNEW_W   = TNEW_W_DEF,
  parameter int          EXC_W    = 5,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = PIPE_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_exc,
  input  logic [EXC_W-1:0]  in_exc_code,
  input  logic              loc_exc,
  input  logic [EXC_W-1:0]  loc_exc_code,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_exc,
  output logic [EXC_W-1:0]  out_exc_code,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_pc;
  logic              r_bd;
  logic [TNEW_W-1:0] r_tnew;
  logic              r_exc;
  logic [EXC_W-1:0]  r_exc_code;

  logic              w_stall_evt;
  logic [TNEW_W-1:0] w_tnew_dec;
  logic              w_exc;
  logic [EXC_W-1:0]  w_exc_code;

  assign w_stall_evt = stall && !flush;
  assign w_tnew_dec  = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

  // The upstream exception is older, so its code takes precedence.
  assign w_exc      = in_exc | loc_exc;
  assign w_exc_code = in_exc  ? in_exc_code  :
                      loc_exc ? loc_exc_code : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_pc       <= RESET_PC;
      r_bd       <= 1'b0;
      r_tnew     <= '0;
      r_exc      <= 1'b0;
      r_exc_code <= '0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_pc       <= in_pc;
      r_bd       <= in_bd;
      r_tnew     <= '0;
      r_exc      <= 1'b0;
      r_exc_code <= '0;
    end else if (!stall) begin
      // An invalid slot still carries its payload but never raises or waits.
      r_valid    <= in_valid;
      r_data     <= in_data;
      r_pc       <= in_pc;
      r_bd       <= in_bd;
      r_tnew     <= in_valid ? w_tnew_dec : '0;
      r_exc      <= in_valid ? w_exc      : 1'b0;
      r_exc_code <= in_valid ? w_exc_code : '0;
    end
  end

  assign out_valid    = r_valid;
  assign out_data     = r_data;
  assign out_pc       = r_pc;
  assign out_bd       = r_bd;
  assign out_tnew     = r_tnew;
  assign out_exc      = r_exc;
  assign out_exc_code = r_exc_code;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_evt),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core; successor to the fixed-field per-stage registers (D/E/M/W). It carries an opaque payload plus a valid bit, supports stall (hold) and flush (bubble insertion) with fixed priority, and counts down the hazard `Tnew` field. It also merges precise-exception status and carries PC and branch-delay flag through bubbles so CP0 always sees a correct EPC. Saturating stall and flush event counters are included for performance debug.

## Interface
- `DATA_W`, 128: opaque payload width (instruction word, operands, control bundle)
- `TNEW_W`, 3: width of `Tnew` field
- `EXC_W`, 5: exception code width (ExcCode)
- `CNT_W`, 16: event counter width
- `RESET_PC`, 32'h0000_3000: PC presented while in reset/bubble-after-reset
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `stall`  in  1  hold current contents
- `flush`  in  1  replace next contents with a bubble
- `in_valid`  in  1  upstream slot holds a real instruction
- `in_data`  in  DATA_W  payload
- `in_pc`  in  32  PC of upstream slot
- `in_bd`  in  1  upstream slot is in a delay slot
- `in_tnew`  in  TNEW_W  cycles until upstream result is ready
- `in_exc`, `in_exc_code`  in  1, EXC_W  exception already raised upstream
- `loc_exc`, `loc_exc_code`  in  1, EXC_W  exception raised by the current upstream stage
- `out_valid`, `out_data`, `out_pc`, `out_bd`, `out_tnew`, `out_exc`, `out_exc_code`  out  matching widths  registered stage outputs
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters

## Operation
- Priority per edge: reset > flush > stall > load.
- Load (`!flush && !stall`): every out field takes its input. `out_tnew` = `in_tnew - 1`, saturating at 0. `out_exc` = `in_exc | loc_exc`. `out_exc_code` = `in_exc ? in_exc_code : (loc_exc ? loc_exc_code : 0)`; the upstream exception wins because it is older.
- Stall (`stall && !flush`): all out fields hold, `out_tnew` included. `stall_cnt` += 1, saturating at all-ones.
- Flush (`flush`, regardless of `stall`): `out_valid`=0, `out_data`=0, `out_tnew`=0, `out_exc`=0, `out_exc_code`=0. `out_pc`=`in_pc` and `out_bd`=`in_bd` (the bubble inherits PC/BD so the EPC stays precise). `flush_cnt` += 1, saturating. Flush with stall counts as a flush only.
- `in_valid`=0 on load: the payload passes through unchanged. `out_exc` is forced to 0 and `out_exc_code` to 0 (no exception from an invalid slot). `out_tnew` is forced to 0.
- Counters are free-running and cleared only by reset.

## Timing
- Latency: exactly 1 cycle from input to output on load; outputs are purely registered with no combinational path from input to output.
- Reset (async assert, synchronous-effect release on the next edge): `out_valid`=0, `out_data`=0, `out_pc`=`RESET_PC`, `out_bd`=0, `out_tnew`=0, `out_exc`=0, `out_exc_code`=0, `stall_cnt`=0, `flush_cnt`=0.
- Reset asserted mid-stall or mid-flush: state clears immediately and is independent of the clock.
- `in_tnew`=0 on load gives `out_tnew`=0 (no wrap).
- Counter at max: it holds at all-ones and never wraps.

## Structure
- Shared package `pipe_pkg`: ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), `RESET_PC` default, and the `Tnew` maximum.
- One natural sub-module, `sat_counter` (parameter W; inputs `inc`; output `count`), instantiated twice for the stall and flush counters.

## Test plan
- Reset: with `reset`=0 mid-cycle, all outputs go to their reset values at once and `out_pc`=32'h0000_3000; after release, the first load with `in_pc`=32'h3004 and `in_tnew`=2 gives `out_pc`=32'h3004 and `out_tnew`=1 one edge later.
- Tnew saturation: loading `in_tnew` values 3, 1, 0 on successive edges gives `out_tnew` of 2, 0, 0.
- Stall then flush: load `in_data`=0xA5, then stall for 3 edges, so `out_data` holds 0xA5 and `stall_cnt`=3. Then assert `stall` and `flush` together with `in_pc`=32'h3010 and `in_bd`=1: the result is `out_valid`=0, `out_pc`=32'h3010, `out_bd`=1, `flush_cnt`=1, and `stall_cnt` stays 3.
- Exception merge: `in_exc`=1 with code 4 and `loc_exc`=1 with code 12 gives `out_exc_code`=4. With `in_exc`=0 the result is code 12. With `in_valid`=0 the result is `out_exc`=0.
- Counter saturation at `CNT_W`=2: 5 consecutive stalls give `stall_cnt` values 1, 2, 3, 3, 3.
